equation_solver_gj: RTL and testbench

EQUATION_SOLVER_GJ -- requirements
Module: equation_solver_gj

---
 rtl/equation_solver_gj.sv | 219 +++++++++++++++++++++
 tb/tb_equation_solver_gj.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/equation_solver_gj.sv
// equation_solver_gj: fixed-point Gauss-Jordan solver with partial pivoting and a shared restoring divider.
// Non-singular accept-to-o_valid latency: N(N+1)/2 + N + (N-1)*(N*(W+F) + N(N+1)/2 + N) + N*(W+F) + 1 cycles.
module equation_solver_gj #(
    parameter int MATRIX_SIZE = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst_n,
    input  logic                                                i_calc_cmd,
    input  logic [DATA_WIDTH*MATRIX_SIZE*(MATRIX_SIZE+1)-1:0]   i_matrix,
    output logic [DATA_WIDTH*MATRIX_SIZE-1:0]                   o_roots,
    output logic                                                o_ready,
    output logic                                                o_valid,
    output logic                                                o_singular
);
    localparam int N  = MATRIX_SIZE;
    localparam int W  = DATA_WIDTH;
    localparam int F  = FRAC_BITS;
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(W + F);
    localparam logic [W+F-1:0] POS_LIM = {{(F + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [W+F-1:0] NEG_LIM = {{F{1'b0}}, 1'b1, {(W - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PIVOT, SWAP, FACTOR, ELIM, ROOT, DONE} state_t;

    state_t state_q, state_d;
    logic [W-1:0] a_q [N][N+1];
    logic [W-1:0] a_d [N][N+1];
    logic [W-1:0] x_q [N];
    logic [W-1:0] x_d [N];
    logic [W-1:0] roots_q [N];
    logic [W-1:0] roots_d [N];
    logic [W-1:0] best_q, best_d, factor_q, factor_d, rem_q, rem_d;
    logic [W+F-1:0] quo_q, quo_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] k_q, k_d, r_q, r_d, piv_q, piv_d, j_q, j_d, i_q, i_d;
    logic [CW-1:0] c_q, c_d;
    logic sing_q, sing_d, ready_q, ready_d, valid_q, valid_d, singular_q, singular_d;

    logic [W-1:0] num_s, den_s, num_mag, den_mag, piv_s, piv_mag, akc, rem_n, div_res, elim_v;
    logic [W+F-1:0] dvd, quo_n;
    logic [W:0] rem_sh;
    logic signed [2*W-1:0] fac_x, akc_x, prod;
    logic [RW:0] nj;
    logic dbit, ge, neg, div_last, upd;

    // Divider reads its operands straight from the buffer, which is stable while it runs.
    always_comb begin
        num_s    = (state_q == ROOT) ? a_q[i_q][CW'(N)] : a_q[j_q][CW'(k_q)];
        den_s    = (state_q == ROOT) ? a_q[i_q][CW'(i_q)] : a_q[k_q][CW'(k_q)];
        num_mag  = num_s[W-1] ? -num_s : num_s;
        den_mag  = den_s[W-1] ? -den_s : den_s;
        dvd      = {num_mag, {F{1'b0}}};
        dbit     = dvd[DW'(W + F - 1) - cnt_q];
        rem_sh   = {rem_q, dbit};
        ge       = rem_sh >= {1'b0, den_mag};
        rem_n    = ge ? W'(rem_sh - {1'b0, den_mag}) : rem_sh[W-1:0];
        quo_n    = (quo_q << 1) | {{(W + F - 1){1'b0}}, ge};
        neg      = num_s[W-1] ^ den_s[W-1];
        div_res  = (!neg && quo_n > POS_LIM) ? {1'b0, {(W - 1){1'b1}}} :
                   (neg && quo_n > NEG_LIM)  ? {1'b1, {(W - 1){1'b0}}} :
                   neg ? -quo_n[W-1:0] : quo_n[W-1:0];
        div_last = cnt_q == DW'(W + F - 1);
        piv_s    = a_q[r_q][CW'(k_q)];
        piv_mag  = piv_s[W-1] ? -piv_s : piv_s;
        upd      = (r_q == k_q) || (piv_mag > best_q);
        akc      = a_q[k_q][c_q];
        fac_x    = {{W{factor_q[W-1]}}, factor_q};
        akc_x    = {{W{akc[W-1]}}, akc};
        prod     = fac_x * akc_x;
        elim_v   = a_q[j_q][c_q] - W'(prod >>> F);
        nj       = {1'b0, j_q} + (RW + 1)'(1);
        if (nj == {1'b0, k_q})
            nj = nj + (RW + 1)'(1);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        x_d        = x_q;
        roots_d    = roots_q;
        best_d     = best_q;
        factor_d   = factor_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        r_d        = r_q;
        piv_d      = piv_q;
        j_d        = j_q;
        i_d        = i_q;
        c_d        = c_q;
        sing_d     = sing_q;
        singular_d = singular_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: if (i_calc_cmd) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c <= N; c++)
                        a_d[r][c] = i_matrix[W*(r*(N+1)+c) +: W];
                k_d     = '0;
                r_d     = '0;
                sing_d  = 1'b0;
                state_d = PIVOT;
            end
            PIVOT: begin
                best_d = upd ? piv_mag : best_q;
                piv_d  = upd ? r_q : piv_q;
                r_d    = r_q + RW'(1);
                if (r_q == RW'(N - 1)) begin
                    sing_d  = best_d == '0;
                    state_d = (best_d == '0) ? DONE : SWAP;
                end
            end
            SWAP: begin
                for (int c = 0; c <= N; c++) begin
                    a_d[k_q][c]   = a_q[piv_q][c];
                    a_d[piv_q][c] = a_q[k_q][c];
                end
                j_d     = (k_q == '0) ? RW'(1) : '0;
                state_d = FACTOR;
            end
            FACTOR, ROOT: begin
                rem_d = div_last ? '0 : rem_n;
                quo_d = div_last ? '0 : quo_n;
                cnt_d = div_last ? '0 : cnt_q + DW'(1);
                if (div_last && state_q == FACTOR) begin
                    factor_d = div_res;
                    c_d      = CW'(k_q);
                    state_d  = ELIM;
                end
                if (div_last && state_q == ROOT) begin
                    x_d[i_q] = div_res;
                    i_d      = i_q + RW'(1);
                    state_d  = (i_q == RW'(N - 1)) ? DONE : ROOT;
                end
            end
            ELIM: begin
                a_d[j_q][c_q] = elim_v;
                c_d           = c_q + CW'(1);
                if (c_q == CW'(N)) begin
                    if (nj < (RW + 1)'(N)) begin
                        j_d     = nj[RW-1:0];
                        state_d = FACTOR;
                    end else if (k_q == RW'(N - 1)) begin
                        i_d     = '0;
                        state_d = ROOT;
                    end else begin
                        k_d     = k_q + RW'(1);
                        r_d     = k_q + RW'(1);
                        state_d = PIVOT;
                    end
                end
            end
            DONE: begin
                for (int i = 0; i < N; i++)
                    roots_d[i] = sing_q ? '0 : x_q[i];
                singular_d = sing_q;
                valid_d    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            a_q        <= '{default: '0};
            x_q        <= '{default: '0};
            roots_q    <= '{default: '0};
            best_q     <= '0;
            factor_q   <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            r_q        <= '0;
            piv_q      <= '0;
            j_q        <= '0;
            i_q        <= '0;
            c_q        <= '0;
            sing_q     <= 1'b0;
            singular_q <= 1'b0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            x_q        <= x_d;
            roots_q    <= roots_d;
            best_q     <= best_d;
            factor_q   <= factor_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            r_q        <= r_d;
            piv_q      <= piv_d;
            j_q        <= j_d;
            i_q        <= i_d;
            c_q        <= c_d;
            sing_q     <= sing_d;
            singular_q <= singular_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_roots
        assign o_roots[W*g +: W] = roots_q[g];
    end
    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_singular = singular_q;
endmodule

// File: tb/tb_equation_solver_gj.sv
// tb_equation_solver_gj: directed scenarios for the Gauss-Jordan solver at N=3, Q16.16.
module tb_equation_solver_gj;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int F  = 16;
    localparam int E  = N * (N + 1);
    localparam int MW = W * E;
    // PIVOT + SWAP + two rows of (divide + column sweep) per k, then three root divides and DONE.
    localparam int LAT = (3 + 1 + 2 * (48 + 4)) + (2 + 1 + 2 * (48 + 3)) + (1 + 1 + 2 * (48 + 2)) + 3 * 48 + 1;
    localparam logic [W-1:0] ONE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd = 1'b0;
    logic [MW-1:0] mat = '0;
    logic [W*N-1:0] roots;
    logic ready, valid, sing;
    int errs = 0;
    int checks = 0;

    equation_solver_gj #(.MATRIX_SIZE(N), .DATA_WIDTH(W), .FRAC_BITS(F)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_calc_cmd(cmd), .i_matrix(mat),
        .o_roots(roots), .o_ready(ready), .o_valid(valid), .o_singular(sing)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mk(input logic [W-1:0] e [E]);
        logic [MW-1:0] m;
        for (int i = 0; i < E; i++)
            m[W*i +: W] = e[i];
        return m;
    endfunction

    task automatic start(input logic [MW-1:0] m);
        mat = m;
        cmd = 1'b1;
        @(posedge clk); #1;
        cmd = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output int rdy);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        rdy = 0;
        while (!seen && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (valid) seen = 1'b1;
            else if (ready) rdy++;
        end
    endtask

    task automatic test_reset;
        checks++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++; if (valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (sing !== 1'b0) begin errs++; $display("FAIL reset_singular: got %b want 0", sing); end
        checks++; if (roots !== '0) begin errs++; $display("FAIL reset_roots: got %h want 0", roots); end
        rst_n = 1'b1;
    endtask

    task automatic test_diag;
        int cyc, rdy;
        logic [W-1:0] e [E];
        logic [W-1:0] ex [N];
        e = '{32'h20000, 0, 0, 32'h20000, 0, 32'h40000, 0, 32'h40000, 0, 0, 32'h80000, 32'h80000};
        ex = '{ONE, ONE, ONE};
        start(mk(e));
        checks++; if (ready !== 1'b0) begin errs++; $display("FAIL diag_ready_drop: got %b want 0", ready); end
        wait_valid(cyc, rdy);
        checks++; if (cyc !== LAT) begin errs++; $display("FAIL diag_latency: got %0d want %0d", cyc, LAT); end
        checks++; if (rdy !== 0) begin errs++; $display("FAIL diag_busy_ready: got %0d ready cycles want 0", rdy); end
        for (int i = 0; i < N; i++) begin
            checks++; if (roots[W*i +: W] !== ex[i]) begin errs++; $display("FAIL diag_root%0d: got %h want %h", i, roots[W*i +: W], ex[i]); end
        end
        checks++; if (sing !== 1'b0) begin errs++; $display("FAIL diag_singular: got %b want 0", sing); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errs++; $display("FAIL diag_pulse: got %b want 0", valid); end
    endtask

    task automatic test_swap;
        int cyc, rdy;
        logic [W-1:0] e [E];
        logic [W-1:0] ex [N];
        e = '{0, ONE, 0, 32'h30000, ONE, 0, 0, 32'h20000, 0, 0, ONE, 32'hFFFB0000};
        ex = '{32'h20000, 32'h30000, 32'hFFFB0000};
        start(mk(e));
        wait_valid(cyc, rdy);
        checks++; if (cyc !== LAT) begin errs++; $display("FAIL swap_latency: got %0d want %0d", cyc, LAT); end
        for (int i = 0; i < N; i++) begin
            checks++; if (roots[W*i +: W] !== ex[i]) begin errs++; $display("FAIL swap_root%0d: got %h want %h", i, roots[W*i +: W], ex[i]); end
        end
        checks++; if (sing !== 1'b0) begin errs++; $display("FAIL swap_singular: got %b want 0", sing); end
    endtask

    task automatic test_elim;
        int cyc, rdy;
        logic [W-1:0] e [E];
        logic [W-1:0] ex [N];
        e = '{32'h20000, ONE, 0, 32'h40000, 32'h40000, 32'h40000, 0, 32'hC0000, 0, 0, ONE, ONE};
        ex = '{ONE, 32'h20000, ONE};
        start(mk(e));
        wait_valid(cyc, rdy);
        checks++; if (cyc !== LAT) begin errs++; $display("FAIL elim_latency: got %0d want %0d", cyc, LAT); end
        for (int i = 0; i < N; i++) begin
            checks++; if (roots[W*i +: W] !== ex[i]) begin errs++; $display("FAIL elim_root%0d: got %h want %h", i, roots[W*i +: W], ex[i]); end
        end
    endtask

    task automatic test_singular;
        int cyc, rdy;
        logic [W-1:0] e [E];
        e = '{ONE, 32'h20000, 32'h30000, 32'h40000, 32'h20000, 32'h40000, 32'h60000, 32'h80000, 0, 0, ONE, ONE};
        start(mk(e));
        wait_valid(cyc, rdy);
        checks++; if (cyc >= 3000) begin errs++; $display("FAIL singular_valid: no o_valid within %0d cycles", cyc); end
        checks++; if (sing !== 1'b1) begin errs++; $display("FAIL singular_flag: got %b want 1", sing); end
        checks++; if (roots !== '0) begin errs++; $display("FAIL singular_roots: got %h want 0", roots); end
        @(posedge clk); #1;
        checks++; if (valid !== 1'b0) begin errs++; $display("FAIL singular_pulse: got %b want 0", valid); end
    endtask

    task automatic test_saturation;
        int cyc, rdy;
        logic [W-1:0] e [E];
        e = '{32'h1, 0, 0, 32'h7FFF0000, 0, ONE, 0, 0, 0, 0, ONE, 0};
        start(mk(e));
        checks++; if (sing !== 1'b1) begin errs++; $display("FAIL sat_singular_held: got %b want 1", sing); end
        checks++; if (roots !== '0) begin errs++; $display("FAIL sat_roots_held: got %h want 0", roots); end
        wait_valid(cyc, rdy);
        checks++; if (cyc !== LAT) begin errs++; $display("FAIL sat_latency: got %0d want %0d", cyc, LAT); end
        checks++; if (roots[W-1:0] !== 32'h7FFFFFFF) begin errs++; $display("FAIL sat_pos_x0: got %h want 7fffffff", roots[W-1:0]); end
        checks++; if (roots[W*N-1:W] !== '0) begin errs++; $display("FAIL sat_pos_x12: got %h want 0", roots[W*N-1:W]); end
        checks++; if (sing !== 1'b0) begin errs++; $display("FAIL sat_singular: got %b want 0", sing); end
        e[3] = 32'h80010000;
        start(mk(e));
        wait_valid(cyc, rdy);
        checks++; if (roots[W-1:0] !== 32'h80000000) begin errs++; $display("FAIL sat_neg_x0: got %h want 80000000", roots[W-1:0]); end
    endtask

    task automatic test_busy;
        int cyc, rdy, n;
        logic [W-1:0] e [E];
        logic [W-1:0] d [E];
        logic [W-1:0] ex [N];
        e = '{0, ONE, 0, 32'h30000, ONE, 0, 0, 32'h20000, 0, 0, ONE, 32'hFFFB0000};
        d = '{32'h20000, 0, 0, 32'h20000, 0, 32'h40000, 0, 32'h40000, 0, 0, 32'h80000, 32'h80000};
        ex = '{32'h20000, 32'h30000, 32'hFFFB0000};
        start(mk(e));
        repeat (10) @(posedge clk);
        #1;
        mat = mk(d);
        cmd = 1'b1;
        @(posedge clk); #1;
        cmd = 1'b0;
        mat = '1;
        wait_valid(cyc, rdy);
        checks++; if (cyc + 11 !== LAT) begin errs++; $display("FAIL busy_latency: got %0d want %0d", cyc + 11, LAT); end
        for (int i = 0; i < N; i++) begin
            checks++; if (roots[W*i +: W] !== ex[i]) begin errs++; $display("FAIL busy_root%0d: got %h want %h", i, roots[W*i +: W], ex[i]); end
        end
        n = 0;
        repeat (600) begin
            @(posedge clk); #1;
            if (valid) n++;
        end
        checks++; if (n !== 0) begin errs++; $display("FAIL busy_extra_valid: got %0d want 0", n); end
        checks++; if (roots[W-1:0] !== 32'h20000) begin errs++; $display("FAIL busy_roots_held: got %h want 00020000", roots[W-1:0]); end
    endtask

    task automatic test_reset_mid;
        int cyc, rdy, n;
        logic [W-1:0] e [E];
        logic [W-1:0] d [E];
        logic [W-1:0] ex [N];
        e = '{32'h20000, ONE, 0, 32'h40000, 32'h40000, 32'h40000, 0, 32'hC0000, 0, 0, ONE, ONE};
        d = '{32'h40000, 0, 0, 32'h20000, 0, 32'h20000, 0, 32'hFFFF0000, 0, 0, ONE, 32'h30000};
        ex = '{32'h8000, 32'hFFFF8000, 32'h30000};
        start(mk(e));
        repeat (52) @(posedge clk);
        #1;
        rst_n = 1'b0;
        mat = mk(d);
        cmd = 1'b1;
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (valid) n++;
        end
        checks++; if (n !== 0) begin errs++; $display("FAIL rstmid_valid: got %0d pulses want 0", n); end
        checks++; if (roots !== '0) begin errs++; $display("FAIL rstmid_roots: got %h want 0", roots); end
        checks++; if (ready !== 1'b1) begin errs++; $display("FAIL rstmid_ready: got %b want 1", ready); end
        checks++; if (sing !== 1'b0) begin errs++; $display("FAIL rstmid_singular: got %b want 0", sing); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        cmd = 1'b0;
        checks++; if (ready !== 1'b0) begin errs++; $display("FAIL rstmid_accept: ready %b want 0", ready); end
        wait_valid(cyc, rdy);
        checks++; if (cyc !== LAT) begin errs++; $display("FAIL rstmid_latency: got %0d want %0d", cyc, LAT); end
        for (int i = 0; i < N; i++) begin
            checks++; if (roots[W*i +: W] !== ex[i]) begin errs++; $display("FAIL rstmid_root%0d: got %h want %h", i, roots[W*i +: W], ex[i]); end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_diag;
        test_swap;
        test_elim;
        test_singular;
        test_saturation;
        test_busy;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
